// File: rtl/warp_addr_coalescer_pkg.sv
// Shared configuration constants for the Tau vector pipeline, including the
// memory line geometry used by the warp address coalescer.
package TauCfg;

   localparam int VSIZE          = 4;
   localparam int GLOBAL_ADDR_BW = 16;
   localparam int N_ICFG         = 4;
   localparam int LINE_SHAMT     = 3;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } coal_state_e;

   // Index width for a range of n values; a single-value range still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/warp_addr_coalescer_leader.sv
// Lowest-set-bit picker: returns the first active lane as one-hot and index.
// An all-zero mask yields a zero one-hot and index 0.
module LeaderSelect
   import TauCfg::*;
#(
   parameter  int W  = VSIZE,
   localparam int IW = clog2_min1(W)
) (
   input  logic [W-1:0]  i_mask,
   output logic [W-1:0]  o_onehot,
   output logic [IW-1:0] o_index
);

   assign o_onehot = i_mask & (~i_mask + W'(1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      o_index = '0;
      for (int i = W - 1; i >= 0; i--) begin
         if (i_mask[i]) begin
            o_index = IW'(i);
         end
      end
   end

endmodule

// File: rtl/warp_addr_coalescer.sv
// Splits one vector of per-lane word addresses into one memory request per
// distinct line, served in ascending leader-lane order.
module warp_addr_coalescer #(
   parameter  int N_CFG      = TauCfg::N_ICFG,
   parameter  int ABW        = TauCfg::GLOBAL_ADDR_BW,
   parameter  int LINE_SHAMT = TauCfg::LINE_SHAMT,
   localparam int VSIZE      = TauCfg::VSIZE,
   localparam int NCFG_BW    = TauCfg::clog2_min1(N_CFG),
   localparam int LBW        = ABW - LINE_SHAMT
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
   input  logic                                i_src_rdy,
   output logic                                o_src_ack,
   input  logic [NCFG_BW-1:0]                  i_id,
   input  logic [VSIZE-1:0][ABW-1:0]           i_address,
   input  logic [VSIZE-1:0]                    i_valid,
   input  logic                                i_retire,
   output logic                                o_dst_rdy,
   input  logic                                i_dst_ack,
   output logic [NCFG_BW-1:0]                  o_id,
   output logic [LBW-1:0]                      o_line,
   output logic [VSIZE-1:0]                    o_lane_mask,
   output logic [VSIZE-1:0][LINE_SHAMT-1:0]    o_lane_ofs,
   output logic                                o_retire,
   output logic                                o_last
);

   localparam int LIW = TauCfg::clog2_min1(VSIZE);

   TauCfg::coal_state_e state_q, state_d;

   logic [VSIZE-1:0]          pending_q, pending_d;
   logic [NCFG_BW-1:0]        id_q, id_d;
   logic                      retire_q, retire_d;
   logic [VSIZE-1:0][ABW-1:0] addr_q, addr_d;

   logic [VSIZE-1:0] lead_onehot;
   logic [LIW-1:0]   lead_idx;
   logic [LBW-1:0]   lead_line;
   logic [VSIZE-1:0] line_eq;
   logic [VSIZE-1:0] req_mask;
   logic             req_last;
   logic             src_xfer;
   logic             dst_xfer;

   LeaderSelect #(
      .W (VSIZE)
   ) u_leader (
      .i_mask   (pending_q),
      .o_onehot (lead_onehot),
      .o_index  (lead_idx)
   );

   // An empty vector has index 0, so its single request reports the lane-0 line.
   always_comb begin
      lead_line  = addr_q[lead_idx][ABW-1:LINE_SHAMT];
      line_eq    = '0;
      o_lane_ofs = '0;
      for (int i = 0; i < VSIZE; i++) begin
         line_eq[i]    = (addr_q[i][ABW-1:LINE_SHAMT] == lead_line);
         o_lane_ofs[i] = addr_q[i][LINE_SHAMT-1:0];
      end
      req_mask = lead_onehot | (pending_q & line_eq);
      req_last = ((pending_q & ~req_mask) == '0);
   end

   assign o_id   = id_q;
   assign o_line = lead_line;

   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      id_d        = id_q;
      retire_d    = retire_q;
      addr_d      = addr_q;
      o_src_ack   = 1'b0;
      o_dst_rdy   = 1'b0;
      o_lane_mask = '0;
      o_last      = 1'b0;
      o_retire    = 1'b0;

      case (state_q)
         TauCfg::IDLE: begin
            o_src_ack = i_src_rdy;
         end
         TauCfg::EMIT: begin
            o_dst_rdy   = 1'b1;
            o_lane_mask = req_mask;
            o_last      = req_last;
            o_retire    = retire_q & req_last;
            // The next vector may enter on the very cycle the last request leaves.
            o_src_ack   = i_src_rdy & i_dst_ack & req_last;
         end
         default: begin
            state_d = TauCfg::IDLE;
         end
      endcase

      if (i_rst) begin
         o_src_ack = 1'b0;
         o_dst_rdy = 1'b0;
      end

      dst_xfer = o_dst_rdy & i_dst_ack;
      src_xfer = o_src_ack & i_src_rdy;

      if (dst_xfer) begin
         pending_d = pending_q & ~req_mask;
         if (req_last) begin
            state_d = TauCfg::IDLE;
         end
      end

      if (src_xfer) begin
         state_d   = TauCfg::EMIT;
         pending_d = i_valid;
         id_d      = i_id;
         retire_d  = i_retire;
         addr_d    = i_address;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= TauCfg::IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

   // NOTE: the address buffer and tags are left unreset; pending = 0 makes their contents irrelevant.
   always_ff @(posedge i_clk) begin
      id_q     <= id_d;
      retire_q <= retire_d;
      addr_q   <= addr_d;
   end

endmodule

// File: tb/tb_warp_addr_coalescer.sv
// Self-checking bench for warp_addr_coalescer: directed vector table, hand-written
// back-to-back / stall / reset sequences, and a randomized run against a line-split model.
module tb_warp_addr_coalescer;

   localparam int NV = 4;
   localparam int AW = 16;
   localparam int LS = 3;
   localparam int LW = AW - LS;

   typedef struct packed {
      logic [1:0]          id;
      logic [LW-1:0]       line;
      logic [NV-1:0]       mask;
      logic [NV-1:0][LS-1:0] ofs;
      logic                retire;
      logic                last;
   } req_t;

   typedef struct packed {
      logic [1:0]          id;
      logic [NV-1:0][AW-1:0] addr;
      logic [NV-1:0]       valid;
      logic                retire;
      logic [2:0]          n_req;
      req_t [3:0]          exp;
   } vec_t;

   logic                  clk;
   logic                  i_rst;
   logic                  i_src_rdy;
   logic                  o_src_ack;
   logic [1:0]            i_id;
   logic [NV-1:0][AW-1:0] i_address;
   logic [NV-1:0]         i_valid;
   logic                  i_retire;
   logic                  o_dst_rdy;
   logic                  i_dst_ack;
   logic [1:0]            o_id;
   logic [LW-1:0]         o_line;
   logic [NV-1:0]         o_lane_mask;
   logic [NV-1:0][LS-1:0] o_lane_ofs;
   logic                  o_retire;
   logic                  o_last;

   logic rand_ack;
   logic rnd_ack;
   logic ack_force;

   int   n_checks;
   int   n_fail;
   req_t sb[$];
   req_t mon_act;
   req_t mon_exp;
   vec_t tbl[5];

   warp_addr_coalescer dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_src_rdy   (i_src_rdy),
      .o_src_ack   (o_src_ack),
      .i_id        (i_id),
      .i_address   (i_address),
      .i_valid     (i_valid),
      .i_retire    (i_retire),
      .o_dst_rdy   (o_dst_rdy),
      .i_dst_ack   (i_dst_ack),
      .o_id        (o_id),
      .o_line      (o_line),
      .o_lane_mask (o_lane_mask),
      .o_lane_ofs  (o_lane_ofs),
      .o_retire    (o_retire),
      .o_last      (o_last)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign i_dst_ack = rand_ack ? rnd_ack : ack_force;

   always @(posedge clk) begin
      #1;
      rnd_ack = ($urandom_range(0, 3) != 0);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [NV-1:0][LS-1:0] ofs_of(input logic [NV-1:0][AW-1:0] a);
      logic [NV-1:0][LS-1:0] r;
      for (int i = 0; i < NV; i++) r[i] = a[i][LS-1:0];
      return r;
   endfunction

   function automatic req_t mk(input logic [1:0] id, input logic [LW-1:0] line,
                               input logic [NV-1:0] mask, input logic [NV-1:0][LS-1:0] ofs,
                               input logic retire, input logic last);
      req_t r;
      r.id = id; r.line = line; r.mask = mask; r.ofs = ofs; r.retire = retire; r.last = last;
      return r;
   endfunction

   // Reference split: repeatedly take the lowest pending lane and claim every pending lane on its line.
   task automatic push_model(input logic [1:0] id, input logic [NV-1:0][AW-1:0] a,
                             input logic [NV-1:0] v, input logic r);
      logic [NV-1:0] pend;
      req_t          e;
      int            lead;
      bit            done;
      pend = v;
      done = 0;
      while (!done) begin
         lead = 0;
         for (int i = NV - 1; i >= 0; i--) if (pend[i]) lead = i;
         e.id   = id;
         e.line = a[lead][AW-1:LS];
         e.mask = '0;
         for (int i = 0; i < NV; i++) if (pend[i] && a[i][AW-1:LS] == e.line) e.mask[i] = 1'b1;
         pend     = pend & ~e.mask;
         e.last   = (pend == '0);
         e.retire = r & e.last;
         e.ofs    = ofs_of(a);
         sb.push_back(e);
         done = e.last;
      end
   endtask

   task automatic send(input logic [1:0] id, input logic [NV-1:0][AW-1:0] a,
                       input logic [NV-1:0] v, input logic r);
      int n;
      n = 0;
      i_id = id; i_address = a; i_valid = v; i_retire = r; i_src_rdy = 1'b1;
      @(negedge clk);
      while (!o_src_ack && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!o_src_ack) begin
         n_checks++;
         n_fail++;
         $display("FAIL src_accept: got no o_src_ack within 200 cycles, expected acceptance");
      end
      @(posedge clk);
      #1;
      i_src_rdy = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check(name, 64'(sb.size()), 64'(0));
      sb.delete();
   endtask

   always @(negedge clk) begin
      if (!i_rst && o_dst_rdy && i_dst_ack) begin
         mon_act = mk(o_id, o_line, o_lane_mask, o_lane_ofs, o_retire, o_last);
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_req: got request 0x%0h, expected none", mon_act);
         end else begin
            mon_exp = sb.pop_front();
            check("req", 64'(mon_act), 64'(mon_exp));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

   initial begin
      logic [NV-1:0][AW-1:0] a;
      logic [NV-1:0]         v;
      n_checks = 0;
      n_fail   = 0;
      rand_ack = 1'b0;
      rnd_ack  = 1'b1;
      ack_force = 1'b1;
      i_rst = 1'b1; i_src_rdy = 1'b1; i_id = '0; i_address = '0; i_valid = '0; i_retire = 1'b0;

      tbl[0] = '0;
      tbl[0].id = 2'd1; tbl[0].addr = {16'h0012, 16'h0017, 16'h0011, 16'h0010};
      tbl[0].valid = 4'b1111; tbl[0].retire = 1'b1; tbl[0].n_req = 3'd1;
      tbl[0].exp[0] = mk(2'd1, 13'h2, 4'b1111, {3'd2, 3'd7, 3'd1, 3'd0}, 1'b1, 1'b1);

      tbl[1] = '0;
      tbl[1].id = 2'd2; tbl[1].addr = {16'h0021, 16'h000F, 16'h0020, 16'h0008};
      tbl[1].valid = 4'b1111; tbl[1].retire = 1'b1; tbl[1].n_req = 3'd2;
      tbl[1].exp[0] = mk(2'd2, 13'h1, 4'b0101, {3'd1, 3'd7, 3'd0, 3'd0}, 1'b0, 1'b0);
      tbl[1].exp[1] = mk(2'd2, 13'h4, 4'b1010, {3'd1, 3'd7, 3'd0, 3'd0}, 1'b1, 1'b1);

      tbl[2] = '0;
      tbl[2].id = 2'd3; tbl[2].addr = {16'h0001, 16'h0002, 16'h0099, 16'h0030};
      tbl[2].valid = 4'b0000; tbl[2].retire = 1'b1; tbl[2].n_req = 3'd1;
      tbl[2].exp[0] = mk(2'd3, 13'h6, 4'b0000, {3'd1, 3'd2, 3'd1, 3'd0}, 1'b1, 1'b1);

      tbl[3] = '0;
      tbl[3].id = 2'd0; tbl[3].addr = {16'h005F, 16'h0058, 16'h0050, 16'h0000};
      tbl[3].valid = 4'b0100; tbl[3].retire = 1'b0; tbl[3].n_req = 3'd1;
      tbl[3].exp[0] = mk(2'd0, 13'hB, 4'b0100, {3'd7, 3'd0, 3'd0, 3'd0}, 1'b0, 1'b1);

      tbl[4] = '0;
      tbl[4].id = 2'd1; tbl[4].addr = {16'h0007, 16'hFFFF, 16'h0000, 16'hFFF8};
      tbl[4].valid = 4'b1111; tbl[4].retire = 1'b0; tbl[4].n_req = 3'd2;
      tbl[4].exp[0] = mk(2'd1, 13'h1FFF, 4'b0101, {3'd7, 3'd7, 3'd0, 3'd0}, 1'b0, 1'b0);
      tbl[4].exp[1] = mk(2'd1, 13'h0000, 4'b1010, {3'd7, 3'd7, 3'd0, 3'd0}, 1'b0, 1'b1);

      // Reset with the source requesting: nothing may be accepted or offered.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_src_ack", 64'(o_src_ack), 64'(0));
      check("rst_dst_rdy", 64'(o_dst_rdy), 64'(0));
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      i_src_rdy = 1'b0;
      @(negedge clk);
      check("idle_dst_rdy", 64'(o_dst_rdy), 64'(0));
      check("idle_last", 64'(o_last), 64'(0));
      check("idle_mask", 64'(o_lane_mask), 64'(0));
      check("idle_retire", 64'(o_retire), 64'(0));
      @(posedge clk);
      #1;

      for (int t = 0; t < 5; t++) begin
         for (int k = 0; k < int'(tbl[t].n_req); k++) sb.push_back(tbl[t].exp[k]);
         send(tbl[t].id, tbl[t].addr, tbl[t].valid, tbl[t].retire);
      end
      drain("table_drain");
      @(posedge clk);
      #1;

      // Back-to-back: B enters while A's single request leaves, then B stalls 5 cycles.
      sb.push_back(mk(2'd2, 13'h8, 4'b1111, {3'd3, 3'd2, 3'd1, 3'd0}, 1'b0, 1'b1));
      send(2'd2, {16'h0043, 16'h0042, 16'h0041, 16'h0040}, 4'b1111, 1'b0);
      a = {16'h0021, 16'h000F, 16'h0020, 16'h0008};
      push_model(2'd3, a, 4'b1111, 1'b0);
      i_id = 2'd3; i_address = a; i_valid = 4'b1111; i_retire = 1'b0; i_src_rdy = 1'b1;
      @(negedge clk);
      check("b2b_src_ack", 64'(o_src_ack), 64'(1));
      @(posedge clk);
      #1;
      i_src_rdy = 1'b0;
      ack_force = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("stall_dst_rdy", 64'(o_dst_rdy), 64'(1));
         check("stall_line", 64'(o_line), 64'(13'h1));
         check("stall_mask", 64'(o_lane_mask), 64'(4'b0101));
         check("stall_last", 64'(o_last), 64'(0));
         check("stall_ofs", 64'(o_lane_ofs), 64'({3'd1, 3'd7, 3'd0, 3'd0}));
      end
      @(posedge clk);
      #1;
      ack_force = 1'b1;
      drain("b2b_drain");
      @(posedge clk);
      #1;

      // Reset while the second of three requests is on offer.
      push_model(2'd1, {16'h0000, 16'h0010, 16'h0008, 16'h0000}, 4'b1111, 1'b1);
      send(2'd1, {16'h0000, 16'h0010, 16'h0008, 16'h0000}, 4'b1111, 1'b1);
      @(posedge clk);
      #1;
      check("rst_pre_count", 64'(sb.size()), 64'(2));
      i_rst = 1'b1;
      @(negedge clk);
      check("midrst_dst_rdy", 64'(o_dst_rdy), 64'(0));
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("postrst_dst_rdy", 64'(o_dst_rdy), 64'(0));
      check("postrst_last", 64'(o_last), 64'(0));
      @(posedge clk);
      #1;
      push_model(2'd2, {16'h0109, 16'h0108, 16'h0101, 16'h0100}, 4'b1111, 1'b1);
      send(2'd2, {16'h0109, 16'h0108, 16'h0101, 16'h0100}, 4'b1111, 1'b1);
      drain("postrst_drain");
      @(posedge clk);
      #1;

      // Randomized vectors with random downstream stalls.
      rand_ack = 1'b1;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < NV; i++) begin
            a[i] = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
         end
         v = 4'($urandom_range(0, 15));
         push_model(2'($urandom_range(0, 3)), a, v, 1'($urandom_range(0, 1)));
         send(sb[sb.size() - 1].id, a, v, sb[sb.size() - 1].retire);
      end
      drain("rand_drain");
      rand_ack = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
